// File: rtl/alu_pkg.sv
// Shared definitions for the pipelined adder/subtractor: op encodings and default sizes.
// Latency: none (definitions only).
// Backpressure: not applicable.
package alu_pkg;

    localparam int DEF_WIDTH = 32;
    localparam int DEF_SEG   = 8;

    typedef enum logic [1:0] {
        OP_ADD = 2'b00,  // a + b
        OP_ADC = 2'b01,  // a + b + cin
        OP_SUB = 2'b10,  // a + ~b + 1
        OP_SBB = 2'b11   // a + ~b + ~cin
    } op_e;

    // Subtract modes add the one's complement of b.
    function automatic logic op_inverts_b(input op_e op);
        return (op == OP_SUB) || (op == OP_SBB);
    endfunction

    // Carry into bit 0; for SBB cin is a borrow, so it enters inverted.
    function automatic logic init_carry(input op_e op, input logic cin);
        logic c;
        case (op)
            OP_ADD:  c = 1'b0;
            OP_ADC:  c = cin;
            OP_SUB:  c = 1'b1;
            default: c = ~cin;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/pipelined_addsub_if.sv
// Operand/result bundle for the pipelined adder/subtractor.
// Latency: none (wiring only).
// Backpressure: in_ready/out_ready carry valid-ready flow control on each side.
// Ports: operand side in_valid/in_ready/a/b/op/cin; result side out_valid/out_ready/s/cout/overflow/zero.
interface pipelined_addsub_if #(
    parameter int WIDTH = alu_pkg::DEF_WIDTH
) ();
    import alu_pkg::*;

    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    op_e              op;
    logic             cin;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] s;
    logic             cout;
    logic             overflow;
    logic             zero;

    // Upstream operand source plus downstream result sink (the bench plays both).
    modport master (
        output in_valid, a, b, op, cin, out_ready,
        input  in_ready, out_valid, s, cout, overflow, zero
    );

    // The arithmetic block itself.
    modport slave (
        input  in_valid, a, b, op, cin, out_ready,
        output in_ready, out_valid, s, cout, overflow, zero
    );

endinterface

// File: rtl/csel_segment.sv
// Combinational SEG-bit carry-select slice: both candidate sums computed, carry-in picks one.
// Latency: 0 (purely combinational).
// Backpressure: none.
// Ports: a/b segment operands, ci carry-in; sum, co carry-out, c_top carry into the top bit, seg_zero.
module csel_segment #(
    parameter int SEG = 8
) (
    input  logic [SEG-1:0] a,
    input  logic [SEG-1:0] b,
    input  logic           ci,
    output logic [SEG-1:0] sum,
    output logic           co,
    output logic           c_top,
    output logic           seg_zero
);

    logic [SEG:0]   sum0;
    logic [SEG:0]   sum1;
    logic [SEG-1:0] low0;
    logic [SEG-1:0] low1;

    always_comb begin
        // Two independent adders so the late-arriving carry only drives the mux.
        sum0 = {1'b0, a} + {1'b0, b};
        sum1 = {1'b0, a} + {1'b0, b} + {{SEG{1'b0}}, 1'b1};
        // Carry into the top bit, needed for signed overflow at the MSB segment.
        low0 = {1'b0, a[SEG-2:0]} + {1'b0, b[SEG-2:0]};
        low1 = {1'b0, a[SEG-2:0]} + {1'b0, b[SEG-2:0]} + {{(SEG-1){1'b0}}, 1'b1};

        sum      = ci ? sum1[SEG-1:0] : sum0[SEG-1:0];
        co       = ci ? sum1[SEG]     : sum0[SEG];
        c_top    = ci ? low1[SEG-1]   : low0[SEG-1];
        seg_zero = ~|sum;
    end

endmodule

// File: rtl/pipelined_addsub.sv
// Pipelined carry-select add/sub: one SEG-bit segment resolved per stage, carry registered between stages.
// Latency: NSEG stages; result valid NSEG edges after the operands are first presented and accepted.
// Backpressure: ready chain from out_ready back to in_ready; a stage loads when empty or when its successor loads.
// Ports: clock, resetn (async active-low), flush (sync clear); bus = operand/result handshake bundle.
module pipelined_addsub
    import alu_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int SEG   = DEF_SEG
) (
    input  logic              clock,
    input  logic              resetn,
    input  logic              flush,
    pipelined_addsub_if.slave bus
);

    localparam int NSEG = WIDTH / SEG;

    // Per-stage state: stage k holds segments 0..k resolved in s, carry out of segment k in c.
    logic [NSEG-1:0]  vld_q, vld_d;
    logic [WIDTH-1:0] a_q [NSEG];
    logic [WIDTH-1:0] a_d [NSEG];
    logic [WIDTH-1:0] b_q [NSEG];
    logic [WIDTH-1:0] b_d [NSEG];
    logic [WIDTH-1:0] s_q [NSEG];
    logic [WIDTH-1:0] s_d [NSEG];
    logic [NSEG-1:0]  c_q, c_d;
    logic [NSEG-1:0]  z_q, z_d;    // all segments resolved so far are zero
    logic             ovf_q, ovf_d;

    // What each stage would load: stage 0 from the bus, stage k from stage k-1.
    logic [NSEG-1:0]  src_vld;
    logic [WIDTH-1:0] src_a [NSEG];
    logic [WIDTH-1:0] src_b [NSEG];
    logic [WIDTH-1:0] src_s [NSEG];
    logic [NSEG-1:0]  src_c;
    logic [NSEG-1:0]  src_z;

    logic [SEG-1:0]   seg_a   [NSEG];
    logic [SEG-1:0]   seg_b   [NSEG];
    logic [SEG-1:0]   seg_sum [NSEG];
    logic [NSEG-1:0]  seg_co;
    logic [NSEG-1:0]  seg_ctop;
    logic [NSEG-1:0]  seg_z;

    logic [WIDTH-1:0] b_in;
    logic             c_init;
    logic [NSEG-1:0]  load;
    logic             tail_full;

    // Ready chain. Unrolled form of load[k] = ~vld[k] | load[k+1]: a stage can load unless
    // it and every stage after it are full while the output is stalled.
    always_comb begin
        tail_full = 1'b1;
        load      = '0;
        for (int k = NSEG - 1; k >= 0; k--) begin
            tail_full = tail_full & vld_q[k];
            load[k]   = bus.out_ready | ~tail_full;
        end
    end

    assign bus.in_ready = load[0];

    always_comb begin
        b_in   = op_inverts_b(bus.op) ? ~bus.b : bus.b;
        c_init = init_carry(bus.op, bus.cin);

        src_vld[0] = bus.in_valid;
        src_a[0]   = bus.a;
        src_b[0]   = b_in;
        src_s[0]   = '0;
        src_c[0]   = c_init;
        src_z[0]   = 1'b1;
        for (int k = 1; k < NSEG; k++) begin
            src_vld[k] = vld_q[k-1];
            src_a[k]   = a_q[k-1];
            src_b[k]   = b_q[k-1];
            src_s[k]   = s_q[k-1];
            src_c[k]   = c_q[k-1];
            src_z[k]   = z_q[k-1];
        end

        for (int k = 0; k < NSEG; k++) begin
            seg_a[k] = src_a[k][k*SEG +: SEG];
            seg_b[k] = src_b[k][k*SEG +: SEG];
        end
    end

    for (genvar g = 0; g < NSEG; g++) begin : g_seg
        csel_segment #(.SEG(SEG)) u_seg (
            .a        (seg_a[g]),
            .b        (seg_b[g]),
            .ci       (src_c[g]),
            .sum      (seg_sum[g]),
            .co       (seg_co[g]),
            .c_top    (seg_ctop[g]),
            .seg_zero (seg_z[g])
        );
    end

    always_comb begin
        vld_d = vld_q;
        a_d   = a_q;
        b_d   = b_q;
        s_d   = s_q;
        c_d   = c_q;
        z_d   = z_q;
        ovf_d = ovf_q;

        for (int k = 0; k < NSEG; k++) begin
            if (load[k]) begin
                vld_d[k] = src_vld[k];
                // Data only moves with a real operation, so a drained output keeps its last value.
                if (src_vld[k]) begin
                    a_d[k]                = src_a[k];
                    b_d[k]                = src_b[k];
                    s_d[k]                = src_s[k];
                    s_d[k][k*SEG +: SEG]  = seg_sum[k];
                    c_d[k]                = seg_co[k];
                    z_d[k]                = src_z[k] & seg_z[k];
                    if (k == NSEG - 1) begin
                        ovf_d = seg_ctop[k] ^ seg_co[k];
                    end
                end
            end
        end

        // Flush wins over any accept or retire on the same edge.
        if (flush) begin
            vld_d = '0;
        end
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            vld_q <= '0;
            c_q   <= '0;
            z_q   <= '0;
            ovf_q <= 1'b0;
            for (int k = 0; k < NSEG; k++) begin
                a_q[k] <= '0;
                b_q[k] <= '0;
                s_q[k] <= '0;
            end
        end else begin
            vld_q <= vld_d;
            a_q   <= a_d;
            b_q   <= b_d;
            s_q   <= s_d;
            c_q   <= c_d;
            z_q   <= z_d;
            ovf_q <= ovf_d;
        end
    end

    assign bus.out_valid = vld_q[NSEG-1];
    assign bus.s         = s_q[NSEG-1];
    assign bus.cout      = c_q[NSEG-1];
    assign bus.overflow  = ovf_q;
    assign bus.zero      = z_q[NSEG-1];

endmodule

// File: tb/tb_pipelined_addsub.sv
// Self-checking bench for pipelined_addsub at WIDTH=32, SEG=8 (4 stages).
// Latency: expects results 4 edges after operands are presented.
// Backpressure: exercises stalls, flush and mid-flight reset.
module tb_pipelined_addsub;
    import alu_pkg::*;

    localparam int WIDTH = 32;
    localparam int SEG   = 8;
    localparam int NSEG  = WIDTH / SEG;

    logic clock  = 1'b0;
    logic resetn = 1'b0;
    logic flush  = 1'b0;

    always #5 clock = ~clock;

    pipelined_addsub_if #(.WIDTH(WIDTH)) bus ();

    pipelined_addsub #(.WIDTH(WIDTH), .SEG(SEG)) dut (
        .clock  (clock),
        .resetn (resetn),
        .flush  (flush),
        .bus    (bus)
    );

    int n_cmp  = 0;
    int n_fail = 0;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic drive(input logic v, input logic [31:0] a, input logic [31:0] b,
                         input op_e op, input logic cin);
        bus.in_valid = v;
        bus.a        = a;
        bus.b        = b;
        bus.op       = op;
        bus.cin      = cin;
    endtask

    // Full-width reference: {cout, overflow, zero, s}.
    function automatic logic [34:0] model(input logic [31:0] a, input logic [31:0] b,
                                          input op_e op, input logic cin);
        logic [31:0] bb;
        logic        c0;
        logic [32:0] full;
        logic [31:0] low;
        bb = (op == OP_SUB || op == OP_SBB) ? ~b : b;
        case (op)
            OP_ADD:  c0 = 1'b0;
            OP_ADC:  c0 = cin;
            OP_SUB:  c0 = 1'b1;
            default: c0 = ~cin;
        endcase
        full = {1'b0, a} + {1'b0, bb} + {32'd0, c0};
        low  = {1'b0, a[30:0]} + {1'b0, bb[30:0]} + {31'd0, c0};
        return {full[32], low[31] ^ full[32], (full[31:0] == 32'd0), full[31:0]};
    endfunction

    task automatic test_reset();
        drive(1'b0, 32'd0, 32'd0, OP_ADD, 1'b0);
        bus.out_ready = 1'b0;
        resetn = 1'b0;
        #3;
        n_cmp++;
        if (bus.out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_out_valid: got %b want 0", bus.out_valid);
        end
        n_cmp++;
        if ({bus.s, bus.cout, bus.overflow, bus.zero} !== 35'd0) begin
            n_fail++;
            $display("FAIL reset_outputs: s=%h cout=%b ovf=%b zero=%b want all 0",
                     bus.s, bus.cout, bus.overflow, bus.zero);
        end
        @(negedge clock);
        resetn = 1'b1;
        tick();
        n_cmp++;
        if (bus.in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_in_ready: got %b want 1", bus.in_ready);
        end
    endtask

    task automatic test_directed();
        logic [31:0] va [8] = '{32'h7FFFFFFF, 32'd5, 32'd0, 32'hFFFFFFFF, 32'd10, 32'd10, 32'd1, 32'h80000000};
        logic [31:0] vb [8] = '{32'd1, 32'd5, 32'd1, 32'd0, 32'd3, 32'd3, 32'd1, 32'd1};
        op_e         vo [8] = '{OP_ADD, OP_SUB, OP_SUB, OP_ADC, OP_SBB, OP_SBB, OP_ADD, OP_SUB};
        logic        vc [8] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
        logic [31:0] vs [8] = '{32'h80000000, 32'd0, 32'hFFFFFFFF, 32'd0, 32'd6, 32'd7, 32'd2, 32'h7FFFFFFF};
        logic        ec [8] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
        logic        ev [8] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
        logic        ez [8] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
        string       vn [8] = '{"add_ovf", "sub_equal", "sub_neg", "adc_ripple",
                                "sbb_borrow", "sbb_noborrow", "add_ignores_cin", "sub_ovf"};
        int lat;
        bus.out_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            drive(1'b1, va[i], vb[i], vo[i], vc[i]);
            lat = 0;
            for (int n = 1; n <= 12; n++) begin
                tick();
                if (n == 1) drive(1'b0, 32'd0, 32'd0, OP_ADD, 1'b0);
                if (bus.out_valid === 1'b1) begin
                    lat = n;
                    break;
                end
            end
            n_cmp++;
            if (lat != NSEG) begin
                n_fail++;
                $display("FAIL %s_latency: got %0d edges want %0d", vn[i], lat, NSEG);
            end
            n_cmp++;
            if ({bus.cout, bus.overflow, bus.zero, bus.s} !== {ec[i], ev[i], ez[i], vs[i]}) begin
                n_fail++;
                $display("FAIL %s: s=%h cout=%b ovf=%b zero=%b, want s=%h cout=%b ovf=%b zero=%b",
                         vn[i], bus.s, bus.cout, bus.overflow, bus.zero, vs[i], ec[i], ev[i], ez[i]);
            end
            tick();
        end
    endtask

    task automatic test_back_to_back();
        logic [34:0] q [$];
        logic [34:0] exp;
        logic [31:0] ra, rb;
        op_e         ro;
        logic        rc;
        int sent = 0, got = 0, cyc = 0, gaps = 0, stalls = 0;
        bus.out_ready = 1'b1;
        while (got < 100 && cyc < 300) begin
            if (bus.out_valid === 1'b1) begin
                n_cmp++;
                if (q.size() == 0) begin
                    n_fail++;
                    $display("FAIL b2b_extra: unexpected result s=%h with nothing outstanding", bus.s);
                end else begin
                    exp = q.pop_front();
                    if ({bus.cout, bus.overflow, bus.zero, bus.s} !== exp) begin
                        n_fail++;
                        $display("FAIL b2b_result_%0d: s=%h cout=%b ovf=%b zero=%b, want s=%h cout=%b ovf=%b zero=%b",
                                 got, bus.s, bus.cout, bus.overflow, bus.zero,
                                 exp[31:0], exp[34], exp[33], exp[32]);
                    end
                end
                got++;
            end else if (got > 0) begin
                gaps++;
            end
            if (bus.in_ready !== 1'b1) stalls++;
            if (sent < 100) begin
                ra = $urandom;
                rb = $urandom;
                ro = op_e'($urandom_range(0, 3));
                rc = 1'($urandom_range(0, 1));
                drive(1'b1, ra, rb, ro, rc);
                q.push_back(model(ra, rb, ro, rc));
                sent++;
            end else begin
                drive(1'b0, 32'd0, 32'd0, OP_ADD, 1'b0);
            end
            tick();
            cyc++;
        end
        n_cmp++;
        if (got != 100) begin
            n_fail++;
            $display("FAIL b2b_count: got %0d results want 100", got);
        end
        n_cmp++;
        if (gaps != 0) begin
            n_fail++;
            $display("FAIL b2b_throughput: %0d bubbles want 0", gaps);
        end
        n_cmp++;
        if (stalls != 0) begin
            n_fail++;
            $display("FAIL b2b_in_ready: low %0d cycles want 0", stalls);
        end
    endtask

    task automatic test_backpressure();
        logic [31:0] pa [6] = '{32'd1, 32'd10, 32'd100, 32'h000000FF, 32'd50, 32'hFFFF0000};
        logic [31:0] pb [6] = '{32'd2, 32'd20, 32'd1, 32'd0, 32'd8, 32'h00010000};
        op_e         po [6] = '{OP_ADD, OP_ADD, OP_SUB, OP_ADC, OP_SBB, OP_ADD};
        logic        pc [6] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
        logic [31:0] ps [6] = '{32'd3, 32'd30, 32'd99, 32'h00000100, 32'd42, 32'd0};
        int idx = 0, got, cyc, gaps, extra;
        logic acc;
        bus.out_ready = 1'b0;
        for (int t = 0; t < 6; t++) begin
            drive(1'b1, pa[idx], pb[idx], po[idx], pc[idx]);
            #1;
            acc = bus.in_ready;
            tick();
            if (acc) idx++;
        end
        n_cmp++;
        if (idx != NSEG) begin
            n_fail++;
            $display("FAIL bp_accepted: got %0d want %0d", idx, NSEG);
        end
        n_cmp++;
        if (bus.in_ready !== 1'b0 || bus.out_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL bp_full: in_ready=%b out_valid=%b want 0/1", bus.in_ready, bus.out_valid);
        end
        tick();
        n_cmp++;
        if (bus.out_valid !== 1'b1 || bus.s !== ps[0]) begin
            n_fail++;
            $display("FAIL bp_hold: out_valid=%b s=%h want 1/%h", bus.out_valid, bus.s, ps[0]);
        end
        bus.out_ready = 1'b1;
        #1;
        n_cmp++;
        if (bus.in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL bp_ready_passthrough: in_ready=%b want 1", bus.in_ready);
        end
        got = 1;
        cyc = 0;
        gaps = 0;
        while (got < 6 && cyc < 40) begin
            acc = bus.in_valid & bus.in_ready;
            tick();
            cyc++;
            if (acc) idx++;
            if (bus.out_valid === 1'b1) begin
                n_cmp++;
                if (bus.s !== ps[got]) begin
                    n_fail++;
                    $display("FAIL bp_result_%0d: s=%h want %h", got, bus.s, ps[got]);
                end
                got++;
            end else begin
                gaps++;
            end
            if (idx < 6) drive(1'b1, pa[idx], pb[idx], po[idx], pc[idx]);
            else drive(1'b0, 32'd0, 32'd0, OP_ADD, 1'b0);
            #1;
        end
        n_cmp++;
        if (got != 6 || gaps != 0) begin
            n_fail++;
            $display("FAIL bp_drain: got %0d results with %0d bubbles want 6/0", got, gaps);
        end
        extra = 0;
        for (int n = 0; n < 4; n++) begin
            tick();
            if (bus.out_valid === 1'b1) extra++;
        end
        n_cmp++;
        if (extra != 0) begin
            n_fail++;
            $display("FAIL bp_duplicate: %0d extra results want 0", extra);
        end
    endtask

    task automatic test_flush();
        int seen = 0, lat = 0;
        bus.out_ready = 1'b1;
        drive(1'b1, 32'h11, 32'h22, OP_ADD, 1'b0); tick();
        drive(1'b1, 32'h33, 32'h44, OP_ADD, 1'b0); tick();
        drive(1'b1, 32'h55, 32'h66, OP_SUB, 1'b0); tick();
        flush = 1'b1;
        drive(1'b1, 32'h77, 32'h88, OP_ADD, 1'b0);
        tick();
        flush = 1'b0;
        drive(1'b0, 32'd0, 32'd0, OP_ADD, 1'b0);
        for (int n = 0; n < 8; n++) begin
            if (bus.out_valid === 1'b1) seen++;
            tick();
        end
        n_cmp++;
        if (seen != 0) begin
            n_fail++;
            $display("FAIL flush_discard: out_valid seen %0d cycles want 0", seen);
        end
        drive(1'b1, 32'h1000, 32'd1, OP_SUB, 1'b0);
        for (int n = 1; n <= 12; n++) begin
            tick();
            if (n == 1) drive(1'b0, 32'd0, 32'd0, OP_ADD, 1'b0);
            if (bus.out_valid === 1'b1) begin
                lat = n;
                break;
            end
        end
        n_cmp++;
        if (lat != NSEG || {bus.cout, bus.overflow, bus.zero, bus.s} !== {3'b100, 32'h00000FFF}) begin
            n_fail++;
            $display("FAIL flush_next_op: lat=%0d s=%h cout=%b ovf=%b zero=%b want lat=%0d s=00000fff cout=1 ovf=0 zero=0",
                     lat, bus.s, bus.cout, bus.overflow, bus.zero, NSEG);
        end
        tick();
    endtask

    task automatic test_reset_midflight();
        int seen = 0, lat = 0;
        bus.out_ready = 1'b1;
        drive(1'b1, 32'h1, 32'h2, OP_ADD, 1'b0); tick();
        drive(1'b1, 32'h3, 32'h4, OP_ADD, 1'b0); tick();
        drive(1'b1, 32'h5, 32'h6, OP_ADD, 1'b0); tick();
        drive(1'b0, 32'd0, 32'd0, OP_ADD, 1'b0);
        #2;
        resetn = 1'b0;
        #1;
        n_cmp++;
        if (bus.out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL rst_out_valid: got %b want 0", bus.out_valid);
        end
        n_cmp++;
        if ({bus.s, bus.cout, bus.overflow, bus.zero} !== 35'd0) begin
            n_fail++;
            $display("FAIL rst_outputs: s=%h cout=%b ovf=%b zero=%b want all 0",
                     bus.s, bus.cout, bus.overflow, bus.zero);
        end
        @(posedge clock);
        @(posedge clock);
        @(negedge clock);
        resetn = 1'b1;
        tick();
        n_cmp++;
        if (bus.in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL rst_in_ready: got %b want 1", bus.in_ready);
        end
        for (int n = 0; n < 6; n++) begin
            if (bus.out_valid === 1'b1) seen++;
            tick();
        end
        n_cmp++;
        if (seen != 0) begin
            n_fail++;
            $display("FAIL rst_discard: out_valid seen %0d cycles want 0", seen);
        end
        drive(1'b1, 32'h00FF00FF, 32'h0000FF01, OP_ADC, 1'b1);
        for (int n = 1; n <= 12; n++) begin
            tick();
            if (n == 1) drive(1'b0, 32'd0, 32'd0, OP_ADD, 1'b0);
            if (bus.out_valid === 1'b1) begin
                lat = n;
                break;
            end
        end
        n_cmp++;
        if (lat != NSEG || {bus.cout, bus.overflow, bus.zero, bus.s} !== {3'b000, 32'h01000001}) begin
            n_fail++;
            $display("FAIL rst_next_op: lat=%0d s=%h cout=%b ovf=%b zero=%b want lat=%0d s=01000001 cout=0 ovf=0 zero=0",
                     lat, bus.s, bus.cout, bus.overflow, bus.zero, NSEG);
        end
        tick();
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: run exceeded %0d ns", 500000);
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset();
        test_directed();
        test_back_to_back();
        test_backpressure();
        test_flush();
        test_reset_midflight();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
